// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register latency counters drive the
// ID stall request, and each source operand is resolved from imm, r0, bypass or regfile.
module id_scoreboard #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NBYP = 2,
  parameter int LW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 rs1_read_i,
  input  logic                 rs2_read_i,
  input  logic [AW-1:0]        rs1_addr_i,
  input  logic [AW-1:0]        rs2_addr_i,
  input  logic [DW-1:0]        imm_i,
  input  logic [DW-1:0]        reg1_data_i,
  input  logic [DW-1:0]        reg2_data_i,
  input  logic [NBYP-1:0]      byp_wreg_i,
  input  logic [NBYP*AW-1:0]   byp_wd_i,
  input  logic [NBYP*DW-1:0]   byp_wdata_i,
  input  logic                 issue_valid_i,
  input  logic                 issue_wreg_i,
  input  logic [AW-1:0]        issue_wd_i,
  input  logic [LW-1:0]        issue_lat_i,
  output logic [DW-1:0]        reg1_o,
  output logic [DW-1:0]        reg2_o,
  output logic                 stallreq_o,
  output logic [(2**AW)-1:0]   busy_o,
  output logic [15:0]          stall_cnt_o
);

  localparam int NREG = 2**AW;

  logic [LW-1:0] cnt [NREG];
  logic          hazard1;
  logic          hazard2;
  logic          issue_acc;

  // Channel 0 is the youngest producer, so the lowest matching index wins.
  function automatic logic [DW-1:0] resolve(
    input logic               rd,
    input logic [AW-1:0]      addr,
    input logic [DW-1:0]      rdata,
    input logic [DW-1:0]      imm,
    input logic [NBYP-1:0]    wreg,
    input logic [NBYP*AW-1:0] wd,
    input logic [NBYP*DW-1:0] wdata
  );
    logic          found;
    logic [DW-1:0] res;
    found = 1'b0;
    res   = rdata;
    if (!rd) begin
      res = imm;
    end else if (addr == '0) begin
      res = '0;
    end else begin
      for (int k = 0; k < NBYP; k++) begin
        if (!found && wreg[k] && (wd[k*AW +: AW] == addr)) begin
          res   = wdata[k*DW +: DW];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    hazard1    = rs1_read_i && (rs1_addr_i != '0) && (cnt[rs1_addr_i] != '0);
    hazard2    = rs2_read_i && (rs2_addr_i != '0) && (cnt[rs2_addr_i] != '0);
    stallreq_o = !rst && (hazard1 || hazard2);
    issue_acc  = issue_valid_i && issue_wreg_i && !stallreq_o && !flush_i &&
                 (issue_wd_i != '0);
    reg1_o     = '0;
    reg2_o     = '0;
    if (!rst) begin
      reg1_o = resolve(rs1_read_i, rs1_addr_i, reg1_data_i, imm_i,
                       byp_wreg_i, byp_wd_i, byp_wdata_i);
      reg2_o = resolve(rs2_read_i, rs2_addr_i, reg2_data_i, imm_i,
                       byp_wreg_i, byp_wd_i, byp_wdata_i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: this array is reset, unlike a data RAM: busy and stall are decoded
    // straight from it, so stale counts would fake hazards after reset.
    for (int r = 0; r < NREG; r++) begin
      if (rst || flush_i || r == 0) begin
        cnt[r] <= '0;
      end else if (issue_acc && (issue_wd_i == AW'(r))) begin
        cnt[r] <= issue_lat_i;
      end else if (cnt[r] != '0) begin
        cnt[r] <= cnt[r] - LW'(1);
      end
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign busy_o[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (stallreq_o && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: a model that tracks the cycle at which each
// register becomes ready is compared with the DUT every cycle, plus literal scenario checks.
module tb_id_scoreboard;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NBYP = 2;
  localparam int LW   = 4;
  localparam int NREG = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush_i;
  logic               rs1_read_i, rs2_read_i;
  logic [AW-1:0]      rs1_addr_i, rs2_addr_i;
  logic [DW-1:0]      imm_i, reg1_data_i, reg2_data_i;
  logic [NBYP-1:0]    byp_wreg_i;
  logic [NBYP*AW-1:0] byp_wd_i;
  logic [NBYP*DW-1:0] byp_wdata_i;
  logic               issue_valid_i, issue_wreg_i;
  logic [AW-1:0]      issue_wd_i;
  logic [LW-1:0]      issue_lat_i;
  logic [DW-1:0]      reg1_o, reg2_o;
  logic               stallreq_o;
  logic [NREG-1:0]    busy_o;
  logic [15:0]        stall_cnt_o;

  id_scoreboard #(.DW(DW), .AW(AW), .NBYP(NBYP), .LW(LW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .rs1_read_i(rs1_read_i), .rs2_read_i(rs2_read_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .imm_i(imm_i), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .byp_wreg_i(byp_wreg_i), .byp_wd_i(byp_wd_i), .byp_wdata_i(byp_wdata_i),
    .issue_valid_i(issue_valid_i), .issue_wreg_i(issue_wreg_i),
    .issue_wd_i(issue_wd_i), .issue_lat_i(issue_lat_i),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .stallreq_o(stallreq_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a register written with latency L at cycle t is pending during
  // cycles t+1 .. t+L, i.e. until cycle ready_at = t+L+1.
  longint ready_at [NREG];
  longint now    = 0;
  longint stalls = 0;
  bit     armed  = 1'b0;

  function automatic bit m_busy(input int r);
    return (r != 0) && (ready_at[r] > now);
  endfunction

  function automatic logic [NREG-1:0] m_busy_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy(r);
    return v;
  endfunction

  function automatic bit m_stall();
    bit h1, h2;
    h1 = rs1_read_i && (rs1_addr_i != 0) && m_busy(int'(rs1_addr_i));
    h2 = rs2_read_i && (rs2_addr_i != 0) && m_busy(int'(rs2_addr_i));
    return !rst && (h1 || h2);
  endfunction

  function automatic logic [DW-1:0] m_oper(input logic rd, input logic [AW-1:0] a,
                                           input logic [DW-1:0] rdata);
    if (rst) return '0;
    if (!rd) return imm_i;
    if (a == 0) return '0;
    for (int k = 0; k < NBYP; k++)
      if (byp_wreg_i[k] && byp_wd_i[k*AW +: AW] == a) return byp_wdata_i[k*DW +: DW];
    return rdata;
  endfunction

  task automatic idle();
    rst = 1'b0; flush_i = 1'b0;
    rs1_read_i = 1'b0; rs2_read_i = 1'b0; rs1_addr_i = '0; rs2_addr_i = '0;
    imm_i = '0; reg1_data_i = '0; reg2_data_i = '0;
    byp_wreg_i = '0; byp_wd_i = '0; byp_wdata_i = '0;
    issue_valid_i = 1'b0; issue_wreg_i = 1'b0; issue_wd_i = '0; issue_lat_i = '0;
  endtask

  task automatic issue(input int wd, input int lat);
    issue_valid_i = 1'b1; issue_wreg_i = 1'b1;
    issue_wd_i = AW'(wd); issue_lat_i = LW'(lat);
  endtask

  // Inputs are driven just after the falling edge; compare, then clock the model.
  task automatic tick();
    bit st;
    #1;
    st = m_stall();
    if (armed) begin
      check("reg1_o", 64'(reg1_o), 64'(m_oper(rs1_read_i, rs1_addr_i, reg1_data_i)));
      check("reg2_o", 64'(reg2_o), 64'(m_oper(rs2_read_i, rs2_addr_i, reg2_data_i)));
      check("stallreq_o", 64'(stallreq_o), 64'(st));
      check("busy_o", 64'(busy_o), 64'(m_busy_vec()));
      check("stall_cnt_o", 64'(stall_cnt_o), (stalls > 65535) ? 64'd65535 : 64'(stalls));
    end
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      stalls = 0;
      armed  = 1'b1;
    end else begin
      if (st) stalls++;
      if (flush_i) begin
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
      end else if (issue_valid_i && issue_wreg_i && !st && issue_wd_i != 0) begin
        ready_at[issue_wd_i] = now + longint'(issue_lat_i) + 1;
      end
    end
    now++;
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("reset busy_o", 64'(busy_o), 64'd0);
    check("reset stall_cnt_o", 64'(stall_cnt_o), 64'd0);

    // Issue r3 latency 2, then read r3: two stall cycles.
    idle(); issue(3, 2); tick();
    idle(); rs1_read_i = 1'b1; rs1_addr_i = 5'd3;
    #1 check("lat2 stall c1", 64'(stallreq_o), 64'd1); check("lat2 busy3 c1", 64'(busy_o[3]), 64'd1);
    tick();
    #1 check("lat2 stall c2", 64'(stallreq_o), 64'd1); check("lat2 busy3 c2", 64'(busy_o[3]), 64'd1);
    tick();
    #1 check("lat2 stall c3", 64'(stallreq_o), 64'd0); check("lat2 busy3 c3", 64'(busy_o[3]), 64'd0);
    check("lat2 stall_cnt", 64'(stall_cnt_o), 64'd2);
    tick();

    // Bypass priority, fallback to regfile, immediate.
    idle(); byp_wreg_i = 2'b11; byp_wd_i = {5'd5, 5'd5};
    byp_wdata_i = {32'h5555FFFF, 32'hAAAA0000};
    rs2_read_i = 1'b1; rs2_addr_i = 5'd5; reg2_data_i = 32'hDEADBEEF; imm_i = 32'h0000CAFE;
    #1 check("byp ch0 priority", 64'(reg2_o), 64'hAAAA0000);
    tick();
    byp_wreg_i = 2'b10;
    #1 check("byp ch1 only", 64'(reg2_o), 64'h5555FFFF);
    tick();
    byp_wreg_i = 2'b00;
    #1 check("regfile fallback", 64'(reg2_o), 64'hDEADBEEF);
    tick();
    rs2_read_i = 1'b0;
    #1 check("imm operand", 64'(reg2_o), 64'h0000CAFE);
    tick();

    // r0 is never bypassed and never stalls.
    idle(); rs1_read_i = 1'b1; rs1_addr_i = '0; byp_wreg_i = 2'b01;
    byp_wd_i = '0; byp_wdata_i = {32'h0, 32'h12345678};
    #1 check("r0 operand", 64'(reg1_o), 64'd0); check("r0 no stall", 64'(stallreq_o), 64'd0);
    tick();

    // Flush clears a pending entry.
    idle(); issue(7, 5); tick();
    idle(); flush_i = 1'b1; rs1_read_i = 1'b1; rs1_addr_i = 5'd7;
    #1 check("busy7 before flush", 64'(busy_o[7]), 64'd1);
    tick();
    flush_i = 1'b0;
    #1 check("flush busy_o", 64'(busy_o), 64'd0); check("flush stall", 64'(stallreq_o), 64'd0);
    tick();

    // Reload of a pending entry overrides its decrement.
    idle(); issue(4, 1); tick();
    issue(4, 3);
    #1 check("reload busy4 t1", 64'(busy_o[4]), 64'd1);
    tick();
    idle();
    #1 check("reload busy4 t2", 64'(busy_o[4]), 64'd1);
    tick(); tick();
    #1 check("reload busy4 t4", 64'(busy_o[4]), 64'd1);
    tick();
    #1 check("reload busy4 t5", 64'(busy_o[4]), 64'd0);
    tick();

    // Latency 0 leaves nothing pending.
    idle(); issue(6, 0); tick();
    idle(); rs1_read_i = 1'b1; rs1_addr_i = 5'd6;
    #1 check("lat0 no stall", 64'(stallreq_o), 64'd0); check("lat0 busy6", 64'(busy_o[6]), 64'd0);
    tick();

    // Randomized traffic on a small register window to provoke hazards.
    repeat (3000) begin
      rst           = ($urandom_range(199) == 0);
      flush_i       = ($urandom_range(39) == 0);
      issue_valid_i = 1'($urandom_range(1));
      issue_wreg_i  = ($urandom_range(3) != 0);
      issue_wd_i    = AW'($urandom_range(7));
      issue_lat_i   = LW'($urandom);
      rs1_read_i    = 1'($urandom_range(1));
      rs2_read_i    = 1'($urandom_range(1));
      rs1_addr_i    = AW'($urandom_range(7));
      rs2_addr_i    = AW'($urandom_range(7));
      imm_i         = $urandom;
      reg1_data_i   = $urandom;
      reg2_data_i   = $urandom;
      byp_wreg_i    = NBYP'($urandom);
      byp_wd_i      = {AW'($urandom_range(7)), AW'($urandom_range(7))};
      byp_wdata_i   = {$urandom, $urandom};
      tick();
    end

    // Saturate the stall counter: reissue r9 lat 15 and keep reading it.
    idle(); rst = 1'b1; tick();
    rst = 1'b0; issue(9, 15); rs1_read_i = 1'b1; rs1_addr_i = 5'd9;
    repeat (70005) tick();
    #1 check("stall_cnt saturated", 64'(stall_cnt_o), 64'hFFFF);
    check("sat stall active", 64'(stallreq_o), 64'd1);
    rst = 1'b1;
    tick();
    idle(); rs1_read_i = 1'b1; rs1_addr_i = 5'd9;
    #1 check("post-rst stall", 64'(stallreq_o), 64'd0);
    check("post-rst stall_cnt", 64'(stall_cnt_o), 64'd0);
    check("post-rst busy_o", 64'(busy_o), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
